// File: rtl/uart_pkg.sv
// Shared types and line levels for the UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_e;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_timer.sv
// Bit-period and bit-index counters for the UART transmitter.
module uart_tx_timer #(
    parameter  int CLKS_PER_BIT = 10,
    parameter  int DATA_BITS    = 8,
    localparam int CW           = $clog2(CLKS_PER_BIT),
    localparam int IW           = $clog2(DATA_BITS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          enable,
    output logic          bit_strobe,
    output logic [IW-1:0] bit_idx,
    output logic          last_bit
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;

    // Held in clear while idle, so every frame starts a fresh period at count 0.
    assign bit_strobe = !clear && (cnt_q == CW'(CLKS_PER_BIT - 1));
    assign bit_idx    = idx_q;
    assign last_bit   = (idx_q == IW'(DATA_BITS - 1));

    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (clear) begin
            cnt_d = '0;
            idx_d = '0;
        end else begin
            cnt_d = bit_strobe ? '0 : cnt_q + CW'(1);
            if (enable && bit_strobe)
                idx_d = idx_q + IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte in, start + LSB-first data + stop out.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 serial_out,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int IW = $clog2(DATA_BITS + 1);

    tx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 serial_q, serial_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic          bit_strobe;
    logic          last_bit;
    logic [IW-1:0] bit_idx;

    uart_tx_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .DATA_BITS   (DATA_BITS)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (state_q == IDLE),
        .enable    (state_q == DATA),
        .bit_strobe(bit_strobe),
        .bit_idx   (bit_idx),
        .last_bit  (last_bit)
    );

    // Line level is computed one edge ahead so serial_out comes straight from a flop.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        serial_d = serial_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                serial_d = IDLE_LEVEL;
                if (tx_valid && ready_q) begin
                    state_d  = START;
                    shreg_d  = tx_data;
                    serial_d = START_BIT;
                end
            end
            START: begin
                if (bit_strobe) begin
                    state_d  = DATA;
                    serial_d = shreg_q[0];
                end
            end
            DATA: begin
                if (bit_strobe) begin
                    shreg_d = shreg_q >> 1;
                    if (last_bit) begin
                        state_d  = STOP;
                        serial_d = STOP_BIT;
                    end else begin
                        serial_d = shreg_q[1];
                    end
                end
            end
            STOP: begin
                if (bit_strobe) begin
                    state_d  = IDLE;
                    serial_d = IDLE_LEVEL;
                    done_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
        busy_d  = !ready_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            serial_q <= IDLE_LEVEL;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            serial_q <= serial_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state_q == DATA)
            assert (bit_idx < IW'(DATA_BITS));
    end

    assign tx_ready   = ready_q;
    assign serial_out = serial_q;
    assign tx_busy    = busy_q;
    assign tx_done    = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: default 10/8 instance plus a 2/5 instance.
module tb_uart_tx;

    localparam int P   = 10;
    localparam int N   = 8;
    localparam int FR  = P * (N + 2);
    localparam int P2  = 2;
    localparam int N2  = 5;
    localparam int FR2 = P2 * (N2 + 2);

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] tx_data = '0;
    logic         tx_valid = 1'b0;
    logic         tx_ready, serial_out, tx_busy, tx_done;

    logic [N2-1:0] d2 = '0;
    logic          v2 = 1'b0;
    logic          r2, s2, b2, dn2;

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(P), .DATA_BITS(N)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .serial_out(serial_out),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done)
    );

    uart_tx #(.CLKS_PER_BIT(P2), .DATA_BITS(N2)) u_dut2 (
        .clk       (clk),
        .rst       (rst),
        .tx_data   (d2),
        .tx_valid  (v2),
        .tx_ready  (r2),
        .serial_out(s2),
        .tx_busy   (b2),
        .tx_done   (dn2)
    );

    int   cyc = 0;
    logic rst_q = 1'b1;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [N-1:0] d;
        int           e0;
    } frm_t;

    frm_t sb[$];

    // Frame monitor: pops the expected frame when the start bit appears and
    // checks every cycle of it against the bench's own framing of the byte.
    frm_t cur;
    bit   inf = 0;
    int   fs, off, k;
    logic expb;
    always @(negedge clk) begin
        if (rst_q) begin
            inf = 0;
            chk("rst_line", serial_out, 1);
            chk("rst_rdy", tx_ready, 1);
            chk("rst_busy", tx_busy, 0);
            chk("rst_done", tx_done, 0);
        end else begin
            if (!inf) begin
                if (serial_out == 1'b0) begin
                    if (sb.size() == 0) chk("unexp_frame", 1, 0);
                    else begin
                        cur = sb.pop_front();
                        inf = 1;
                        fs  = cyc;
                        chk("start_edge", cyc, cur.e0);
                    end
                end else begin
                    chk("idle_rdy", tx_ready, 1);
                    chk("idle_busy", tx_busy, 0);
                    chk("idle_done", tx_done, 0);
                end
            end
            if (inf) begin
                off = cyc - fs;
                k   = off / P;
                if (off < FR) begin
                    expb = (k == 0) ? 1'b0 : (k <= N) ? cur.d[k-1] : 1'b1;
                    chk("line", serial_out, expb);
                    chk("busy", tx_busy, 1);
                    chk("rdy", tx_ready, 0);
                    chk("done", tx_done, 0);
                end else begin
                    chk("end_line", serial_out, 1);
                    chk("end_done", tx_done, 1);
                    chk("end_rdy", tx_ready, 1);
                    chk("end_busy", tx_busy, 0);
                    inf = 0;
                end
            end
        end
    end

    // Called at posedge+1; returns the edge number at which the byte was accepted.
    task automatic send(input logic [N-1:0] d, input bit hold, output int e0);
        bit ok = 0;
        e0       = -1;
        tx_data  = d;
        tx_valid = 1'b1;
        for (int i = 0; i < 500 && !ok; i++) begin
            if (tx_ready) begin
                e0 = cyc + 1;
                ok = 1;
                sb.push_back('{d, e0});
            end
            @(posedge clk); #1;
        end
        if (!ok) chk("accept_timeout", 0, 1);
        if (!hold) tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            if (sb.size() == 0 && !inf) ok = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        if (!ok) chk("idle_timeout", 0, 1);
        repeat (20) @(posedge clk);
        #1;
    endtask

    logic exp2[$];
    int   e0a, e0b;

    initial begin
        tx_valid = 1'b1;
        tx_data  = 8'h5A;
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        tx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        send(8'hA5, 0, e0a);
        wait_idle();

        send(8'h00, 1, e0a);
        send(8'hFF, 0, e0b);
        chk("b2b_gap", e0b - e0a, FR + 1);
        wait_idle();

        send(8'hA5, 0, e0a);
        repeat (34) @(posedge clk);
        #1;
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        wait_idle();

        send(8'hC3, 0, e0a);
        repeat (44) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        repeat (5) @(posedge clk);
        #1;
        send(8'h81, 0, e0a);
        wait_idle();

        chk("p2_rdy", r2, 1);
        d2 = 5'h15;
        v2 = 1'b1;
        for (int b = 0; b < N2 + 2; b++)
            for (int c = 0; c < P2; c++)
                exp2.push_back((b == 0) ? 1'b0 : (b <= N2) ? d2[b-1] : 1'b1);
        @(posedge clk); #1;
        v2 = 1'b0;
        for (int i = 0; i < FR2; i++) begin
            @(negedge clk);
            chk("p2_line", s2, exp2.pop_front());
            chk("p2_busy", b2, 1);
            chk("p2_done", dn2, 0);
        end
        @(negedge clk);
        chk("p2_end_line", s2, 1);
        chk("p2_end_done", dn2, 1);
        chk("p2_end_rdy", r2, 1);
        @(negedge clk);
        chk("p2_done_pulse", dn2, 0);

        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
